led_matrix_scan: RTL and testbench

- Downstream display stage for the stacker game.
- Consumes the 64-bit `map` frame from the game logic and time-multiplexes it onto the 8x8 LED matrix via JA (columns) and JB (rows).
- Latches one full frame per scan so the display never tears, inserts a blanking gap between rows to prevent ghosting, and applies 8-step brightness PWM.
- Instantiated in the top level beside score_main; replaces direct JA/JB driving.

---
 rtl/stacker_pkg.sv | 21 ++
 rtl/row_pwm_timer.sv | 40 ++++
 rtl/led_matrix_scan.sv | 120 ++++++++++++
 tb/tb_led_matrix_scan.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/stacker_pkg.sv
// Shared definitions for the stacker display path: matrix geometry,
// frame bit indexing and the scan-state encoding.
package stacker_pkg;

    localparam int MATRIX_DIM = 8;
    localparam int ROW_W      = 3;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ON,
        OFF
    } scan_state_t;

    // Row 0 is the bottom of the matrix; each row occupies one byte of the frame.
    function automatic logic [5:0] map_index(input logic [ROW_W-1:0] row,
                                             input logic [ROW_W-1:0] col);
        return 6'(MATRIX_DIM * int'(row) + int'(col));
    endfunction

endpackage

// File: rtl/row_pwm_timer.sv
// Row-slot timebase: counts cycles within a row slot and steps through the rows,
// flagging the last cycle of each slot and of each frame.
module row_pwm_timer
    import stacker_pkg::*;
#(
    parameter int ROW_TICKS = 12500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output logic [15:0]      tick_cnt,
    output logic [ROW_W-1:0] row_idx,
    output logic             slot_end,
    output logic             frame_wrap
);

    localparam logic [15:0]      LAST_TICK = 16'(ROW_TICKS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(MATRIX_DIM - 1);

    assign slot_end   = (tick_cnt == LAST_TICK);
    assign frame_wrap = slot_end && (row_idx == LAST_ROW);

    // Holding advance low parks the timebase at row 0, cycle 0 so a restart
    // always begins a fresh frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            row_idx  <= '0;
        end else if (!advance) begin
            tick_cnt <= '0;
            row_idx  <= '0;
        end else if (slot_end) begin
            tick_cnt <= '0;
            row_idx  <= row_idx + ROW_W'(1);
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/led_matrix_scan.sv
// Time-multiplexes a latched 64-bit frame onto the 8x8 LED matrix with
// inter-row blanking and 8-step brightness PWM.
module led_matrix_scan
    import stacker_pkg::*;
#(
    parameter int ROW_TICKS      = 12500,
    parameter int BLANK_TICKS    = 64,
    parameter bit COL_ACTIVE_LOW = 1'b1,
    parameter bit ROW_ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             reset_input,
    input  logic             en,
    input  logic [63:0]      map,
    input  logic [2:0]       brightness,
    output logic [7:0]       JA,
    output logic [7:0]       JB,
    output logic [ROW_W-1:0] row_idx,
    output logic             frame_start
);

    localparam logic [15:0] BLANK_LEN  = 16'(BLANK_TICKS);
    localparam logic [18:0] ACTIVE_LEN = 19'(ROW_TICKS - BLANK_TICKS);
    localparam logic [7:0]  COL_OFF    = COL_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [7:0]  ROW_OFF    = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;

    scan_state_t      state;
    scan_state_t      next_state;
    logic [63:0]      shadow;
    logic [63:0]      next_shadow;
    logic [15:0]      on_ticks;
    logic [15:0]      next_on;
    logic [15:0]      calc_on;
    logic [18:0]      product;
    logic [15:0]      tick_cnt;
    logic [15:0]      next_tick;
    logic [ROW_W-1:0] next_row;
    logic [7:0]       lit_cols;
    logic [7:0]       row_sel;
    logic             slot_end;
    logic             frame_wrap;
    logic             latch;
    logic             advance;

    assign advance = en && (state != IDLE);

    row_pwm_timer #(
        .ROW_TICKS (ROW_TICKS)
    ) u_timer (
        .clk        (clk),
        .rst        (reset_input),
        .advance    (advance),
        .tick_cnt   (tick_cnt),
        .row_idx    (row_idx),
        .slot_end   (slot_end),
        .frame_wrap (frame_wrap)
    );

    // Brightness 7 yields the full active window, so BLANK+on never overruns the slot.
    always_comb begin
        product = ACTIVE_LEN * (19'(brightness) + 19'd1);
        calc_on = 16'(product >> 3);
        if (calc_on == 16'd0) begin
            calc_on = 16'd1;
        end
    end

    // Outputs are registered, so everything here describes the cycle after the edge:
    // its slot position, its row, and the frame data it will show.
    always_comb begin
        latch       = (state == IDLE) || frame_wrap;
        next_tick   = ((state == IDLE) || slot_end) ? 16'd0 : tick_cnt + 16'd1;
        next_row    = (state == IDLE) ? '0 : (slot_end ? row_idx + ROW_W'(1) : row_idx);
        next_on     = latch ? calc_on : on_ticks;
        next_shadow = latch ? map : shadow;

        if (next_tick < BLANK_LEN) begin
            next_state = BLANK;
        end else if ({1'b0, next_tick} < ({1'b0, BLANK_LEN} + {1'b0, next_on})) begin
            next_state = ON;
        end else begin
            next_state = OFF;
        end

        lit_cols = '0;
        for (int c = 0; c < MATRIX_DIM; c++) begin
            lit_cols[c] = next_shadow[map_index(next_row, 3'(c))];
        end
        row_sel = 8'd1 << next_row;
    end

    always_ff @(posedge clk or posedge reset_input) begin
        if (reset_input) begin
            state       <= IDLE;
            JA          <= COL_OFF;
            JB          <= ROW_OFF;
            frame_start <= 1'b0;
            shadow      <= '0;
            on_ticks    <= '0;
        end else if (!en) begin
            state       <= IDLE;
            JA          <= COL_OFF;
            JB          <= ROW_OFF;
            frame_start <= 1'b0;
        end else begin
            state       <= next_state;
            shadow      <= next_shadow;
            on_ticks    <= next_on;
            frame_start <= latch;
            if (next_state == ON) begin
                JA <= COL_ACTIVE_LOW ? ~lit_cols : lit_cols;
                JB <= ROW_ACTIVE_LOW ? ~row_sel : row_sel;
            end else begin
                JA <= COL_OFF;
                JB <= ROW_OFF;
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Self-checking bench for led_matrix_scan: a frame-counter reference model
// predicts every output cycle while directed and random stimulus is applied.
module tb_led_matrix_scan;

    localparam int RT    = 16;
    localparam int BT    = 2;
    localparam int FRAME = RT * 8;

    logic        clk = 1'b0;
    logic        reset_input;
    logic        en;
    logic [63:0] map;
    logic [2:0]  brightness;
    logic [7:0]  JA;
    logic [7:0]  JB;
    logic [2:0]  row_idx;
    logic        frame_start;

    int tests_run    = 0;
    int tests_failed = 0;

    bit          m_active = 1'b0;
    int          m_n      = 0;
    logic [63:0] m_shadow = '0;
    int          m_on     = 0;
    bit          m_fs     = 1'b0;

    led_matrix_scan #(
        .ROW_TICKS      (RT),
        .BLANK_TICKS    (BT),
        .COL_ACTIVE_LOW (1'b1),
        .ROW_ACTIVE_LOW (1'b0)
    ) dut (
        .clk         (clk),
        .reset_input (reset_input),
        .en          (en),
        .map         (map),
        .brightness  (brightness),
        .JA          (JA),
        .JB          (JB),
        .row_idx     (row_idx),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic int onTicksFor(input logic [2:0] b);
        int t;
        t = ((RT - BT) * (int'(b) + 1)) / 8;
        return (t < 1) ? 1 : t;
    endfunction

    // Model position is a single cycle number within the frame; row and slot
    // cycle fall out by division.
    task automatic modelStep();
        if (reset_input) begin
            m_active = 1'b0;
            m_n      = 0;
            m_fs     = 1'b0;
        end else if (!en) begin
            m_active = 1'b0;
            m_n      = 0;
            m_fs     = 1'b0;
        end else begin
            if (m_active) begin
                m_n = (m_n + 1) % FRAME;
            end else begin
                m_active = 1'b1;
                m_n      = 0;
            end
            m_fs = (m_n == 0);
            if (m_n == 0) begin
                m_shadow = map;
                m_on     = onTicksFor(brightness);
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [7:0] exp_ja;
        logic [7:0] exp_jb;
        logic [2:0] exp_row;
        int k;
        int r;
        k       = m_n % RT;
        r       = m_n / RT;
        exp_ja  = 8'hFF;
        exp_jb  = 8'h00;
        exp_row = m_active ? 3'(r) : 3'd0;
        if (m_active && k >= BT && k < BT + m_on) begin
            exp_jb = 8'h01 << r;
            exp_ja = ~m_shadow[8*r +: 8];
        end
        tests_run++;
        assert (JA === exp_ja) else begin
            tests_failed++;
            $error("[TB] FAIL %s JA observed=%h expected=%h", tag, JA, exp_ja);
        end
        tests_run++;
        assert (JB === exp_jb) else begin
            tests_failed++;
            $error("[TB] FAIL %s JB observed=%h expected=%h", tag, JB, exp_jb);
        end
        tests_run++;
        assert (row_idx === exp_row) else begin
            tests_failed++;
            $error("[TB] FAIL %s row_idx observed=%0d expected=%0d", tag, row_idx, exp_row);
        end
        tests_run++;
        assert (frame_start === m_fs) else begin
            tests_failed++;
            $error("[TB] FAIL %s frame_start observed=%b expected=%b", tag, frame_start, m_fs);
        end
        tests_run++;
        assert ($countones(JB) <= 1) else begin
            tests_failed++;
            $error("[TB] FAIL %s JB_onehot observed=%h expected=at most one bit", tag, JB);
        end
        if (m_active && k < BT) begin
            tests_run++;
            assert (JB === 8'h00) else begin
                tests_failed++;
                $error("[TB] FAIL %s JB_blank observed=%h expected=00", tag, JB);
            end
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    task automatic applyStimulus(input bit e, input logic [63:0] m, input logic [2:0] b);
        en         = e;
        map        = m;
        brightness = b;
    endtask

    task automatic runUntil(input int target, input string tag);
        int guard;
        guard = 0;
        while (!(m_active && m_n == target) && guard < 2 * FRAME) begin
            tick(tag);
            guard++;
        end
        tests_run++;
        assert (m_active && m_n == target) else begin
            tests_failed++;
            $error("[TB] FAIL %s timeout observed=%0d expected=%0d", tag, m_n, target);
        end
    endtask

    initial begin
        reset_input = 1'b1;
        applyStimulus(1'b0, 64'h0, 3'd0);
        repeat (3) tick("reset");

        reset_input = 1'b0;
        applyStimulus(1'b1, 64'h0000_0000_0000_00A5, 3'd7);
        repeat (2 * FRAME) tick("bright7");

        brightness = 3'd3;
        repeat (FRAME) tick("bright3");
        brightness = 3'd0;
        repeat (FRAME) tick("bright0");

        applyStimulus(1'b1, {$urandom, $urandom}, 3'($urandom_range(0, 7)));
        runUntil(0, "sync_frame");
        runUntil(3 * RT + 5, "to_row3");
        map = {$urandom, $urandom};
        repeat (FRAME) tick("midframe_map");

        runUntil(5 * RT + 4, "to_row5");
        en = 1'b0;
        tick("en_drop");
        repeat (3) tick("idle");
        brightness = 3'd7;
        en = 1'b1;
        tick("reenable");
        repeat (RT) tick("after_reenable");

        runUntil(2 * RT + 6, "to_on");
        #2;
        reset_input = 1'b1;
        #1;
        m_active = 1'b0;
        m_n      = 0;
        m_fs     = 1'b0;
        checkOutput("async_reset");
        tick("reset_hold");
        reset_input = 1'b0;
        tick("post_reset");
        repeat (RT) tick("post_reset_run");

        runUntil(FRAME - 1, "to_wrap");
        en = 1'b0;
        tick("wrap_drop");
        en = 1'b1;
        tick("wrap_restart");

        for (int i = 0; i < 4 * FRAME; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                map        = {$urandom, $urandom};
                brightness = 3'($urandom_range(0, 7));
            end
            en = ($urandom_range(0, 199) != 0);
            tick("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
